io_out_hs_scheduler: RTL

// Shares one handshake parallel output interface (TSR at BASE_ADDR, TBR at BASE_ADDR+1) between two byte producers.

---
 rtl/io_bus_pkg.sv | 22 ++
 rtl/rr_arbiter_2.sv | 20 ++
 rtl/io_out_hs_scheduler.sv | 124 ++++++++++++
 3 files changed

// File: rtl/io_bus_pkg.sv
// io_bus_pkg: shared I/O bus widths, register offsets
// and the scheduler state encoding.
package io_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] TSR_OFS = 16'd0;
  localparam logic [ADDR_W-1:0] TBR_OFS = 16'd1;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RD_SETUP   = 3'd1,
    S_RD_STROBE  = 3'd2,
    S_RD_RELEASE = 3'd3,
    S_WR_SETUP   = 3'd4,
    S_WR_STROBE  = 3'd5,
    S_WR_HOLD    = 3'd6,
    S_ACK        = 3'd7
  } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: combinational two-way round-robin arbiter.
// req[1:0], last_grant in -> one-hot gnt[1:0] out.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // contention: favour the port not served last
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/io_out_hs_scheduler.sv
// io_out_hs_scheduler: shares one TSR/TBR handshake output port between two byte producers.
// Ports: clock/reset, req0/req1 valid/data/ready, I/O bus addr/data/ior_/iow_, busy, drop.
module io_out_hs_scheduler
  import io_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR     = 16'h0ABC,
  parameter int                FO_BIT        = 5,
  parameter int                STROBE_CYCLES = 2,
  parameter int                POLL_MAX      = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data,
  output logic              ior_,
  output logic              iow_,
  output logic              busy,
  output logic              drop
);

  localparam logic [7:0] STR_LAST = 8'(STROBE_CYCLES - 1);
  localparam logic [8:0] POLL_LIM = 9'(POLL_MAX);

  state_t            state;
  state_t            nstate;
  logic [1:0]        gnt;
  logic [7:0]        str_cnt;
  logic [7:0]        poll_cnt;
  logic [DATA_W-1:0] byte_q;
  logic              gid;
  logic              last_grant;
  logic              fo_q;
  logic              drop_q;
  logic              wr_ph;
  logic              str_last;
  logic              poll_hit;

  rr_arbiter_2 u_arb (
    .req       ({req1_valid, req0_valid}),
    .last_grant(last_grant),
    .gnt       (gnt)
  );

  assign str_last = (str_cnt == STR_LAST);
  assign poll_hit = ({1'b0, poll_cnt} + 9'd1) == POLL_LIM;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE:       if (|gnt) nstate = S_RD_SETUP;
      S_RD_SETUP:   nstate = S_RD_STROBE;
      S_RD_STROBE:  if (str_last) nstate = S_RD_RELEASE;
      S_RD_RELEASE: begin
        if (fo_q)          nstate = S_WR_SETUP;
        else if (poll_hit) nstate = S_ACK;
        else               nstate = S_RD_SETUP;
      end
      S_WR_SETUP:   nstate = S_WR_STROBE;
      S_WR_STROBE:  if (str_last) nstate = S_WR_HOLD;
      S_WR_HOLD:    nstate = S_ACK;
      S_ACK:        nstate = S_IDLE;
      default:      nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      str_cnt    <= '0;
      poll_cnt   <= '0;
      byte_q     <= '0;
      gid        <= 1'b0;
      last_grant <= 1'b1;
      fo_q       <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      if (state == S_RD_STROBE || state == S_WR_STROBE)
        str_cnt <= str_last ? 8'd0 : str_cnt + 8'd1;
      else
        str_cnt <= 8'd0;
      if (state == S_IDLE && |gnt) begin
        byte_q     <= gnt[1] ? req1_data : req0_data;
        gid        <= gnt[1];
        last_grant <= gnt[1];
        poll_cnt   <= '0;
        drop_q     <= 1'b0;
      end
      // if/else so an unknown FO bit lands as 0
      if (state == S_RD_STROBE && str_last) begin
        if (data[FO_BIT]) fo_q <= 1'b1;
        else              fo_q <= 1'b0;
      end
      if (state == S_RD_RELEASE && !fo_q) begin
        if (poll_cnt != 8'hFF) poll_cnt <= poll_cnt + 8'd1;
        if (poll_hit) drop_q <= 1'b1;
      end
    end
  end

  always_comb begin
    wr_ph      = (state == S_WR_SETUP) || (state == S_WR_STROBE) ||
                 (state == S_WR_HOLD);
    ior_       = (state != S_RD_STROBE);
    iow_       = (state != S_WR_STROBE);
    addr       = wr_ph ? BASE_ADDR + TBR_OFS : BASE_ADDR + TSR_OFS;
    busy       = (state != S_IDLE);
    req0_ready = (state == S_ACK) && !gid;
    req1_ready = (state == S_ACK) && gid;
    drop       = (state == S_ACK) && drop_q;
  end

  assign data = wr_ph ? byte_q : 'z;

endmodule
